// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM
// encodings, and the fault and byte-enable helpers used by the steering logic.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_REQ    = ST_REQ,
    S_WAIT_R = ST_WAIT_R,
    S_FIN    = ST_FIN
  } lsu_state_t;

  // Misaligned access or a funct3 code that has no meaning for the direction.
  function automatic logic lsu_fault(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = |lo;
      default:     bad = 1'b1;
    endcase
    if (is_store && f3[2]) bad = 1'b1;
    return bad;
  endfunction

  // Width comes from funct3[1:0]; the sign bit does not change the lanes.
  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Combinational lane logic: store data replication and byte enables on the way
// out, lane selection with sign/zero extension on the way back.
module lsu_lane_steer
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be = lsu_be(st_funct3, st_addr_lo);
    case (st_funct3[1:0])
      2'd0:    st_data = {4{st_wdata[7:0]}};
      2'd1:    st_data = {2{st_wdata[15:0]}};
      default: st_data = st_wdata;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    byte_sel = ld_raw[7:0];
      2'd1:    byte_sel = ld_raw[15:8];
      2'd2:    byte_sel = ld_raw[23:16];
      default: byte_sel = ld_raw[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    ld_data = ld_raw;
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I MEM-step load/store unit: one req/gnt/rvalid transaction per start,
// with the aligned load result held in rdata for write-back.
module load_store_unit
  import rv32_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: mem_req stays high with mem_* frozen until a cycle where
  // mem_gnt=1 is seen; for loads one read word is then taken on the first
  // mem_rvalid. mem_gnt/mem_rvalid are ignored in every other state.

  logic [1:0]  state;
  logic        st_r;
  logic [2:0]  f3_r;
  logic [1:0]  lo_r;
  logic        err_r;
  logic        fault;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  lsu_lane_steer u_steer (
    .st_funct3  (funct3),
    .st_addr_lo (addr[1:0]),
    .st_wdata   (wdata),
    .st_be      (st_be),
    .st_data    (st_data),
    .ld_funct3  (f3_r),
    .ld_addr_lo (lo_r),
    .ld_raw     (mem_rdata),
    .ld_data    (ld_data)
  );

  assign fault = lsu_fault(is_store, funct3, addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      st_r      <= 1'b0;
      f3_r      <= 3'd0;
      lo_r      <= 2'd0;
      err_r     <= 1'b0;
      rdata     <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            st_r      <= is_store;
            f3_r      <= funct3;
            lo_r      <= addr[1:0];
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= st_be;
            mem_we    <= is_store & ~fault;
            mem_wdata <= is_store ? st_data : 32'd0;
            err_r     <= fault;
            state     <= fault ? ST_FIN : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) state <= st_r ? ST_FIN : ST_WAIT_R;
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            rdata <= ld_data;
            state <= ST_FIN;
          end
        end
        default: begin
          err_r <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from flops, so no input reaches an output.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign err       = err_r;
  assign mem_req   = (state == ST_REQ);
  assign dbg_state = state;

endmodule
